m_vmem_line_draw: RTL and testbench
===================================

// Module: m_vmem_line_draw
// PURPOSE
//  Bresenham line-drawing engine upstream of the 256x256 video memory (vmem) that feeds m_st7789_disp.
//  Accepts one line command at a time (endpoints + RGB565 colour) over a valid/ready handshake.
//  Emits one vmem write per clock, {y,x} addressed, replacing the hard-coded per-pixel pattern generator.
// PARAMETERS
//  SCREEN_W  240  visible width; x >= SCREEN_W is off-screen (used only with clipping)
//  SCREEN_H  240  visible height; y >= SCREEN_H is off-screen (used only with clipping)
// PORTS
//  w_clk      in   1   system clock (100MHz)
//  w_rst      in   1   synchronous reset, active-high
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   engine idle, can accept a command
//  cmd_x0     in   8   start x
//  cmd_y0     in   8   start y
//  cmd_x1     in   8   end x
//  cmd_y1     in   8   end y
//  cmd_color  in   16  RGB565 pixel value
//  vm_we      out  1   vmem write enable
//  vm_wadr    out  16  vmem write address {y[7:0], x[7:0]}
//  vm_wdata   out  16  vmem write data (latched cmd_color)
//  busy       out  1   high in SETUP/DRAW/DONE
//  done       out  1   one-cycle pulse after the last pixel of a line
// BEHAVIOUR
//  Reset: state=IDLE, cmd_ready=1, vm_we=0, vm_wadr=0, vm_wdata=0, busy=0, done=0; all internal regs 0.
//  States: IDLE -> SETUP -> DRAW -> DONE -> IDLE.
//  IDLE: cmd_ready=1; on cmd_valid&&cmd_ready (cycle T) latch x0,y0,x1,y1,color; go SETUP.
//   cmd_valid outside IDLE is ignored (cmd_ready=0); the command must be held until accepted.
//  SETUP (T+1): dx=|x1-x0| (9b), dy=-|y1-y0| (10b signed), sx=(x1>=x0)?+1:-1, sy=(y1>=y0)?+1:-1,
//   err=dx+dy (10b signed); cur_x=x0, cur_y=y0. No write.
//  DRAW (first write registered at T+2): each cycle vm_we=1, vm_wadr={cur_y,cur_x}, vm_wdata=color.
//   If cur_x==x1 && cur_y==y1: this is the last pixel; go DONE.
//   Else e2=2*err (11b signed); if e2>=dy: x+=sx, add dy; if e2<=dx: y+=sy, add dx;
//   both sums applied to err in the same cycle (err <= err + (c1?dy:0) + (c2?dx:0)).
//  Pixel count = max(|x1-x0|,|y1-y0|)+1, one per cycle, no gaps, no stalls.
//  DONE: vm_we=0, done=1 for exactly one cycle; next cycle IDLE, cmd_ready=1.
//   Earliest back-to-back acceptance is the cycle after DONE.
//  Outputs registered; vm_we deasserts the cycle after the last write.
//  Degenerate line (x0==x1 && y0==y1): exactly one write, then DONE.
//  Coordinates are 8-bit; no wrap occurs (the walk never leaves the bounding box of the endpoints).
//  Reset mid-line: the next cycle has vm_we=0, state IDLE, done=0, and the command is discarded.
//  Reset has priority over a simultaneous cmd_valid.
// CONFIGURATION
//  LINE_CLIP_EN defined: a pixel with cur_x>=SCREEN_W or cur_y>=SCREEN_H still takes its DRAW cycle,
//   but vm_we=0 for it. Cycle count and done timing are unchanged.
//  LINE_CLIP_EN undefined: every pixel in 0..255 is written (vmem is 256x256; off-screen area is unseen).
// TESTING
//  1 horiz (28,128)->(228,128), color FFFF -> 201 writes, wadr 0x801C..0x80E4 step 1, done at T+203.
//  2 point (5,7)->(5,7), color F800 -> single write wadr 0x0705, data F800, done next cycle.
//  3 diagonal (168,188)->(228,128) -> 61 writes, x+1 and y-1 each, last wadr 0x80E4.
//  4 steep (0,0)->(3,10) -> 11 writes, y increments every cycle, x ends 3; err never overflows.
//  5 reset asserted on the 5th write of test 1 -> vm_we=0 next cycle, cmd_ready=1, no done pulse.
//  6 (230,0)->(250,0): LINE_CLIP_EN -> 10 writes (x 230..239), done at T+23; undefined -> 21 writes.

Source files
------------

// File: rtl/m_vmem_line_draw.sv
// m_vmem_line_draw: Bresenham line engine feeding the 256x256 vmem.
// Accepts one line command over valid/ready and emits one {y,x}-addressed
// write per clock until the end point is reached, then pulses done.
// Optional feature macro: LINE_CLIP_EN (suppress writes for pixels with
// x >= SCREEN_W or y >= SCREEN_H while keeping the cycle timing).
module m_vmem_line_draw #(
    parameter int SCREEN_W = 240,
    parameter int SCREEN_H = 240
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_x0,
    input  logic [7:0]  cmd_y0,
    input  logic [7:0]  cmd_x1,
    input  logic [7:0]  cmd_y1,
    input  logic [15:0] cmd_color,
    output logic        vm_we,
    output logic [15:0] vm_wadr,
    output logic [15:0] vm_wdata,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_DRAW  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state;
    logic [7:0]         x0_q;
    logic [7:0]         y0_q;
    logic [7:0]         x1_q;
    logic [7:0]         y1_q;
    logic [15:0]        color_q;
    logic [8:0]         dx;
    logic signed [9:0]  dy;
    logic signed [9:0]  err;
    logic               sx_pos;
    logic               sy_pos;
    logic [7:0]         cur_x;
    logic [7:0]         cur_y;

    logic [7:0]         abs_x;
    logic [7:0]         abs_y;
    logic signed [10:0] e2;
    logic               step_x;
    logic               step_y;
    logic               last_pix;
    logic signed [11:0] err_next;

    // Bresenham step decision and error update for the current pixel
    always_comb begin
        abs_x    = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
        abs_y    = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
        e2       = $signed({err, 1'b0});
        step_x   = (e2 >= $signed({dy[9], dy}));
        step_y   = (e2 <= $signed({2'b00, dx}));
        last_pix = (cur_x == x1_q) && (cur_y == y1_q);
        err_next = $signed({{2{err[9]}}, err})
                 + (step_x ? $signed({{2{dy[9]}}, dy}) : 12'sd0)
                 + (step_y ? $signed({3'b000, dx})     : 12'sd0);
    end

`ifdef LINE_CLIP_EN
    logic on_screen;

    // A pixel is visible only inside the SCREEN_W x SCREEN_H window
    always_comb begin
        on_screen = ({24'd0, cur_x} < SCREEN_W) && ({24'd0, cur_y} < SCREEN_H);
    end
`endif

    // Command acceptance, setup, pixel walk and done pulse
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            vm_we     <= 1'b0;
            vm_wadr   <= 16'd0;
            vm_wdata  <= 16'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            x0_q      <= 8'd0;
            y0_q      <= 8'd0;
            x1_q      <= 8'd0;
            y1_q      <= 8'd0;
            color_q   <= 16'd0;
            dx        <= 9'd0;
            dy        <= 10'sd0;
            err       <= 10'sd0;
            sx_pos    <= 1'b0;
            sy_pos    <= 1'b0;
            cur_x     <= 8'd0;
            cur_y     <= 8'd0;
        end else begin
            done  <= 1'b0;
            vm_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        x0_q      <= cmd_x0;
                        y0_q      <= cmd_y0;
                        x1_q      <= cmd_x1;
                        y1_q      <= cmd_y1;
                        color_q   <= cmd_color;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    dx     <= {1'b0, abs_x};
                    dy     <= 10'sd0 - $signed({2'b00, abs_y});
                    err    <= $signed({2'b00, abs_x}) - $signed({2'b00, abs_y});
                    sx_pos <= (x1_q >= x0_q);
                    sy_pos <= (y1_q >= y0_q);
                    cur_x  <= x0_q;
                    cur_y  <= y0_q;
                    state  <= ST_DRAW;
                end
                ST_DRAW: begin
`ifdef LINE_CLIP_EN
                    vm_we <= on_screen;
`else
                    vm_we <= 1'b1;
`endif
                    vm_wadr  <= {cur_y, cur_x};
                    vm_wdata <= color_q;
                    if (last_pix) begin
                        state <= ST_DONE;
                    end else begin
                        if (step_x) begin
                            cur_x <= sx_pos ? (cur_x + 8'd1) : (cur_x - 8'd1);
                        end
                        if (step_y) begin
                            cur_y <= sy_pos ? (cur_y + 8'd1) : (cur_y - 8'd1);
                        end
                        err <= err_next[9:0];
                    end
                end
                default: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_vmem_line_draw.sv
// tb_m_vmem_line_draw: directed bench for the Bresenham line engine.
// Build with +define+LINE_CLIP_EN to check the clipped variant of the off-screen line.
module tb_m_vmem_line_draw;

    logic        w_clk;
    logic        w_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x0;
    logic [7:0]  cmd_y0;
    logic [7:0]  cmd_x1;
    logic [7:0]  cmd_y1;
    logic [15:0] cmd_color;
    logic        vm_we;
    logic [15:0] vm_wadr;
    logic [15:0] vm_wdata;
    logic        busy;
    logic        done;

    int          n_tests;
    int          n_fail;
    logic [15:0] wr_adr[$];
    logic [15:0] wr_dat[$];
    logic [15:0] exp_adr[$];
    int          done_cyc;
    int          done_cnt;
    int          timeout;
    int          ready_after;
    int          busy_at_done;
    int          nw;
    int          hit;
    int          extra;
    int          saw_done;

    m_vmem_line_draw dut (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .vm_we     (vm_we),
        .vm_wadr   (vm_wadr),
        .vm_wdata  (vm_wdata),
        .busy      (busy),
        .done      (done)
    );

    // 100 MHz clock
    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    // Single comparison point: counts the test and reports a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one line command and record every write until one cycle after done
    task automatic applyStimulus(input logic [7:0] x0, input logic [7:0] y0,
                                 input logic [7:0] x1, input logic [7:0] y1,
                                 input logic [15:0] col);
        wr_adr.delete();
        wr_dat.delete();
        done_cyc     = -1;
        done_cnt     = 0;
        timeout      = 1;
        ready_after  = 0;
        busy_at_done = 1;
        checkOutput("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_x0    = x0;
        cmd_y0    = y0;
        cmd_x1    = x1;
        cmd_y1    = y1;
        cmd_color = col;
        cmd_valid = 1'b1;
        @(posedge w_clk);
        #1;
        cmd_valid = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge w_clk);
            #1;
            if (vm_we) begin
                wr_adr.push_back(vm_wadr);
                wr_dat.push_back(vm_wdata);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = c;
                    busy_at_done = int'(busy);
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                ready_after = int'(cmd_ready);
                timeout     = 0;
                break;
            end
        end
    endtask

    // Compare the recorded writes and handshake timing against exp_adr
    task automatic checkLine(input string tag, input int exp_done, input logic [15:0] col);
        checkOutput({tag, "_timeout"}, timeout, 32'd0);
        checkOutput({tag, "_count"}, wr_adr.size(), exp_adr.size());
        for (int i = 0; i < exp_adr.size(); i++) begin
            checkOutput($sformatf("%s_adr%0d", tag, i),
                        (i < wr_adr.size()) ? {16'd0, wr_adr[i]} : 32'hFFFF_FFFF,
                        {16'd0, exp_adr[i]});
            checkOutput($sformatf("%s_dat%0d", tag, i),
                        (i < wr_dat.size()) ? {16'd0, wr_dat[i]} : 32'hFFFF_FFFF,
                        {16'd0, col});
        end
        checkOutput({tag, "_done_cycle"}, done_cyc, exp_done);
        checkOutput({tag, "_done_pulses"}, done_cnt, 32'd1);
        checkOutput({tag, "_busy_at_done"}, busy_at_done, 32'd0);
        checkOutput({tag, "_ready_after"}, ready_after, 32'd1);
    endtask

    // Directed test sequence
    initial begin
        logic [7:0] steep_x[11];
        n_tests   = 0;
        n_fail    = 0;
        w_rst     = 1'b1;
        cmd_valid = 1'b0;
        cmd_x0    = 8'd0;
        cmd_y0    = 8'd0;
        cmd_x1    = 8'd0;
        cmd_y1    = 8'd0;
        cmd_color = 16'd0;
        steep_x   = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3};

        repeat (3) @(posedge w_clk);
        #1;
        checkOutput("rst_we",    {31'd0, vm_we},     32'd0);
        checkOutput("rst_wadr",  {16'd0, vm_wadr},   32'd0);
        checkOutput("rst_wdata", {16'd0, vm_wdata},  32'd0);
        checkOutput("rst_busy",  {31'd0, busy},      32'd0);
        checkOutput("rst_done",  {31'd0, done},      32'd0);
        checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd1);
        w_rst = 1'b0;
        @(posedge w_clk);
        #1;

        $display("[TB] test 1: horizontal line");
        exp_adr.delete();
        for (int i = 0; i <= 200; i++) exp_adr.push_back(16'h8000 | 16'(28 + i));
        applyStimulus(8'd28, 8'd128, 8'd228, 8'd128, 16'hFFFF);
        checkLine("t1", 203, 16'hFFFF);

        $display("[TB] test 2: single point");
        exp_adr.delete();
        exp_adr.push_back(16'h0705);
        applyStimulus(8'd5, 8'd7, 8'd5, 8'd7, 16'hF800);
        checkLine("t2", 3, 16'hF800);

        $display("[TB] test 3: diagonal up-right");
        exp_adr.delete();
        for (int i = 0; i <= 60; i++) exp_adr.push_back({8'(188 - i), 8'(168 + i)});
        applyStimulus(8'd168, 8'd188, 8'd228, 8'd128, 16'h07E0);
        checkLine("t3", 63, 16'h07E0);
        checkOutput("t3_last_adr", (wr_adr.size() > 0) ? {16'd0, wr_adr[$]} : 32'hFFFF_FFFF, 32'h80E4);

        $display("[TB] test 4: steep line");
        exp_adr.delete();
        for (int i = 0; i <= 10; i++) exp_adr.push_back({8'(i), steep_x[i]});
        applyStimulus(8'd0, 8'd0, 8'd3, 8'd10, 16'h001F);
        checkLine("t4", 13, 16'h001F);

        $display("[TB] test 5: reset during a line");
        cmd_x0    = 8'd28;
        cmd_y0    = 8'd128;
        cmd_x1    = 8'd228;
        cmd_y1    = 8'd128;
        cmd_color = 16'hFFFF;
        cmd_valid = 1'b1;
        @(posedge w_clk);
        #1;
        cmd_valid = 1'b0;
        nw       = 0;
        hit      = 0;
        saw_done = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge w_clk);
            #1;
            if (vm_we) nw++;
            if (done) saw_done = 1;
            if (nw == 5) begin
                hit = 1;
                break;
            end
        end
        checkOutput("t5_reached_5th_write", hit, 32'd1);
        w_rst     = 1'b1;
        cmd_valid = 1'b1;
        @(posedge w_clk);
        #1;
        checkOutput("t5_we_after_rst",    {31'd0, vm_we},     32'd0);
        checkOutput("t5_ready_after_rst", {31'd0, cmd_ready}, 32'd1);
        checkOutput("t5_done_after_rst",  {31'd0, done},      32'd0);
        @(posedge w_clk);
        #1;
        checkOutput("t5_rst_beats_valid", {31'd0, busy},      32'd0);
        cmd_valid = 1'b0;
        w_rst     = 1'b0;
        extra     = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge w_clk);
            #1;
            if (vm_we) extra++;
            if (done) saw_done = 1;
        end
        checkOutput("t5_no_writes_after", extra,    32'd0);
        checkOutput("t5_no_done_pulse",   saw_done, 32'd0);

        $display("[TB] test 6: line crossing the right screen edge");
        exp_adr.delete();
`ifdef LINE_CLIP_EN
        for (int i = 0; i <= 9; i++) exp_adr.push_back(16'(230 + i));
`else
        for (int i = 0; i <= 20; i++) exp_adr.push_back(16'(230 + i));
`endif
        applyStimulus(8'd230, 8'd0, 8'd250, 8'd0, 16'hABCD);
        checkLine("t6", 23, 16'hABCD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
